// File: rtl/debounce_multi_if.sv
// Signal bundle for debounce_multi: raw switch levels in, clean levels and one-cycle events out.
interface debounce_multi_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0] din;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          tick;
    logic [CH-1:0] long_press;

    modport master (output din, input dout, rise, fall, tick, long_press);
    modport slave  (input din, output dout, rise, fall, tick, long_press);
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel unanimous-sample switch debouncer with a shared sample prescaler.
// Optional long-press detector compiled in with `define DEBOUNCE_LONGPRESS_EN.
module debounce_multi #(
    parameter int unsigned CH         = 4,
    parameter int unsigned PSC_DIV    = 250000,
    parameter int unsigned SAMPLES    = 3,
    parameter int unsigned LONG_TICKS = 40
) (
    input logic             clk,
    input logic             rst_n,
    debounce_multi_if.slave bus
);
    localparam int unsigned PW = $clog2(PSC_DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(PSC_DIV - 1);

    if (CH < 1 || PSC_DIV < 2 || SAMPLES < 2 || LONG_TICKS < 1) begin : g_bad_cfg
        $error("debounce_multi: parameter out of range");
    end

    logic [PW-1:0]      psc_q;
    logic               tick_c;
    logic [1:0]         sync_q [CH];
    logic [SAMPLES-1:0] samp_q [CH];
    logic [CH-1:0]      all_ones_c;
    logic [CH-1:0]      all_zeros_c;
    logic [CH-1:0]      dout_q;
    logic [CH-1:0]      rise_q;
    logic [CH-1:0]      fall_q;

    // Shared sample strobe: last count of the prescaler period.
    assign tick_c = (psc_q == PSC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else if (tick_c) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + PW'(1);
        end
    end

    // Two-flop synchroniser feeding a shift register that only advances on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= 2'b00;
                samp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][0], bus.din[i]};
                if (tick_c) begin
                    samp_q[i] <= {samp_q[i][SAMPLES-2:0], sync_q[i][1]};
                end
            end
        end
    end

    always_comb begin
        all_ones_c  = '0;
        all_zeros_c = '0;
        for (int i = 0; i < CH; i++) begin
            all_ones_c[i]  = &samp_q[i];
            all_zeros_c[i] = ~|samp_q[i];
        end
    end

    // Mixed sample windows leave the level untouched, giving hysteresis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            dout_q <= (dout_q | all_ones_c) & ~all_zeros_c;
            rise_q <= all_ones_c & ~dout_q;
            fall_q <= all_zeros_c & dout_q;
        end
    end

    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.tick = tick_c;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

    logic [HW-1:0] hold_q [CH];
    logic [CH-1:0] long_q;

    // Hold counter saturates, so the pulse fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                hold_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                long_q[i] <= dout_q[i] & tick_c & (hold_q[i] == HOLD_PRE);
                if (!dout_q[i]) begin
                    hold_q[i] <= '0;
                end else if (tick_c && (hold_q[i] != HOLD_MAX)) begin
                    hold_q[i] <= hold_q[i] + HW'(1);
                end
            end
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi with CH=2, PSC_DIV=4, SAMPLES=3, LONG_TICKS=5.
// Expected events are queued as stimulus is driven and popped when the DUT pulses.
`timescale 1ns/1ps
module tb_debounce_multi;
    localparam int unsigned CH         = 2;
    localparam int unsigned PSC_DIV    = 4;
    localparam int unsigned SAMPLES    = 3;
    localparam int unsigned LONG_TICKS = 5;
    localparam int LAT_MIN = (SAMPLES - 1) * PSC_DIV + 4;
    localparam int LAT_MAX = SAMPLES * PSC_DIV + 3;

    typedef struct {
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] dout;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int rise_cnt [2];
    int fall_cnt [2];
    int lp_cnt   = 0;
    int both_cnt = 0;
    int dbl_cnt  = 0;
    logic [1:0] prev_rise = 2'b00;
    logic [1:0] prev_fall = 2'b00;
    logic [1:0] prev_lp   = 2'b00;
    exp_t exp_q [$];

    debounce_multi_if #(.CH(CH)) bus ();

    debounce_multi #(
        .CH        (CH),
        .PSC_DIV   (PSC_DIV),
        .SAMPLES   (SAMPLES),
        .LONG_TICKS(LONG_TICKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event bookkeeping: pulse counts, simultaneous rise/fall, pulses wider than one cycle.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            rise_cnt[c] <= rise_cnt[c] + (bus.rise[c] === 1'b1 ? 1 : 0);
            fall_cnt[c] <= fall_cnt[c] + (bus.fall[c] === 1'b1 ? 1 : 0);
        end
        lp_cnt <= lp_cnt + $countones(bus.long_press);
        if ((bus.rise & bus.fall) != 2'b00) both_cnt <= both_cnt + 1;
        if (((bus.rise & prev_rise) | (bus.fall & prev_fall) | (bus.long_press & prev_lp)) != 2'b00)
            dbl_cnt <= dbl_cnt + 1;
        prev_rise <= bus.rise;
        prev_fall <= bus.fall;
        prev_lp   <= bus.long_press;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected the run to end well before 100000 ns");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [1:0] v);
        @(posedge clk);
        #1 bus.din = v;
    endtask

    // Waits (bounded) for the next rise/fall pulse and captures the outputs of that cycle.
    task automatic wait_event(output bit got, output int at,
                              output logic [1:0] r, output logic [1:0] f, output logic [1:0] d);
        got = 1'b0;
        at  = -1;
        r   = 2'b00;
        f   = 2'b00;
        d   = 2'b00;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((bus.rise | bus.fall) != 2'b00) begin
                got = 1'b1;
                at  = cyc;
                r   = bus.rise;
                f   = bus.fall;
                d   = bus.dout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.din = 2'b00;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.dout, bus.rise, bus.fall, bus.tick, bus.long_press} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all 0",
                     {bus.dout, bus.rise, bus.fall, bus.tick, bus.long_press});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.tick !== ((n % 4) == 3)) begin
                errors++;
                $display("FAIL tick_phase edge %0d: got %b, expected %b", n, bus.tick, ((n % 4) == 3));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_glitch();
        int r0;
        for (int off = 0; off < 4; off++) begin
            r0 = rise_cnt[0];
            repeat (off) @(posedge clk);
            drive(2'b01);
            repeat (3) @(posedge clk);
            #1 bus.din = 2'b00;
            repeat (20) @(posedge clk);
            #1;
            checks++;
            if (rise_cnt[0] != r0 || bus.dout !== 2'b00) begin
                errors++;
                $display("FAIL glitch offset %0d: dout %b rises %0d, expected dout 00 rises %0d",
                         off, bus.dout, rise_cnt[0] - r0, 0);
            end
        end
    endtask

    task automatic test_step();
        int t0, at;
        bit got;
        logic [1:0] r, f, d;
        exp_t e;
        exp_q.push_back('{rise: 2'b01, fall: 2'b00, dout: 2'b01});
        drive(2'b01);
        t0 = cyc;
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {r, f, d} !== {e.rise, e.fall, e.dout}) begin
            errors++;
            $display("FAIL step_event: got seen=%0d rise %b fall %b dout %b, expected rise %b fall %b dout %b",
                     got, r, f, d, e.rise, e.fall, e.dout);
        end
        checks++;
        if (!got || (at - t0) < LAT_MIN || (at - t0) > LAT_MAX) begin
            errors++;
            $display("FAIL step_latency: got %0d edges, expected %0d..%0d", at - t0, LAT_MIN, LAT_MAX);
        end
        @(negedge clk);
        checks++;
        if (bus.rise !== 2'b00 || bus.dout !== 2'b01) begin
            errors++;
            $display("FAIL step_pulse_width: rise %b dout %b, expected rise 00 dout 01", bus.rise, bus.dout);
        end
    endtask

    task automatic test_chatter();
        int t0, at, f1;
        bit got;
        logic [1:0] r, f, d;
        exp_t e;
        exp_q.push_back('{rise: 2'b10, fall: 2'b00, dout: 2'b11});
        drive(2'b11);
        t0 = cyc;
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {r, f, d} !== {e.rise, e.fall, e.dout} || (at - t0) < LAT_MIN || (at - t0) > LAT_MAX) begin
            errors++;
            $display("FAIL chatter_setup: got seen=%0d lat %0d rise %b fall %b dout %b, expected rise %b fall %b dout %b",
                     got, at - t0, r, f, d, e.rise, e.fall, e.dout);
        end
        @(posedge clk);
        #1;
        f1 = fall_cnt[1];
        for (int k = 0; k < 10; k++) begin
            bus.din[1] = ((k % 2) == 1);
            repeat (4) @(posedge clk);
            #1;
        end
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 2'b11 || fall_cnt[1] != f1) begin
            errors++;
            $display("FAIL chatter_hold: dout %b falls %0d, expected dout 11 falls 0", bus.dout, fall_cnt[1] - f1);
        end
    endtask

    task automatic test_both_release();
        int t0, at;
        bit got;
        logic [1:0] r, f, d;
        exp_t e;
        exp_q.push_back('{rise: 2'b00, fall: 2'b11, dout: 2'b00});
        drive(2'b00);
        t0 = cyc;
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {r, f, d} !== {e.rise, e.fall, e.dout}) begin
            errors++;
            $display("FAIL both_release: got seen=%0d rise %b fall %b dout %b, expected rise %b fall %b dout %b",
                     got, r, f, d, e.rise, e.fall, e.dout);
        end
        checks++;
        if (!got || (at - t0) < LAT_MIN || (at - t0) > LAT_MAX) begin
            errors++;
            $display("FAIL both_latency: got %0d edges, expected %0d..%0d", at - t0, LAT_MIN, LAT_MAX);
        end
        @(negedge clk);
        checks++;
        if (bus.fall !== 2'b00) begin
            errors++;
            $display("FAIL both_pulse_width: fall %b, expected 00", bus.fall);
        end
    endtask

`ifdef DEBOUNCE_LONGPRESS_EN
    task automatic test_long_press();
        int at, ticks, lp_tick, n0;
        bit got;
        logic [1:0] r, f, d, lp_val;
        exp_t e;
        exp_q.push_back('{rise: 2'b01, fall: 2'b00, dout: 2'b01});
        drive(2'b01);
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {r, f, d} !== {e.rise, e.fall, e.dout}) begin
            errors++;
            $display("FAIL long_press_rise: got seen=%0d rise %b dout %b, expected rise %b dout %b",
                     got, r, d, e.rise, e.dout);
        end
        ticks   = (bus.tick === 1'b1) ? 1 : 0;
        lp_tick = -1;
        lp_val  = 2'b00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lp_tick < 0 && bus.long_press !== 2'b00) begin
                lp_tick = ticks;
                lp_val  = bus.long_press;
            end
            if (bus.tick === 1'b1) ticks++;
        end
        checks++;
        if (lp_tick != LONG_TICKS || lp_val !== 2'b01) begin
            errors++;
            $display("FAIL long_press_fire: got after %0d ticks value %b, expected after %0d ticks value 01",
                     lp_tick, lp_val, LONG_TICKS);
        end
        @(posedge clk);
        n0 = lp_cnt;
        repeat (40) @(posedge clk);
        checks++;
        if (lp_cnt != n0) begin
            errors++;
            $display("FAIL long_press_once: got %0d extra pulses, expected 0", lp_cnt - n0);
        end
        exp_q.push_back('{rise: 2'b00, fall: 2'b01, dout: 2'b00});
        drive(2'b00);
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        exp_q.push_back('{rise: 2'b01, fall: 2'b00, dout: 2'b01});
        drive(2'b01);
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        @(posedge clk);
        n0 = lp_cnt;
        repeat (30) @(posedge clk);
        checks++;
        if (lp_cnt != n0 + 1) begin
            errors++;
            $display("FAIL long_press_repress: got %0d pulses, expected 1", lp_cnt - n0);
        end
        exp_q.push_back('{rise: 2'b00, fall: 2'b01, dout: 2'b00});
        drive(2'b00);
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {r, f, d} !== {e.rise, e.fall, e.dout}) begin
            errors++;
            $display("FAIL long_press_release: got seen=%0d fall %b dout %b, expected fall %b dout %b",
                     got, f, d, e.fall, e.dout);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int at, fc;
        bit got, seen;
        logic [1:0] r, f, d;
        exp_t e;
        exp_q.push_back('{rise: 2'b01, fall: 2'b00, dout: 2'b01});
        drive(2'b01);
        wait_event(got, at, r, f, d);
        e = exp_q.pop_front();
        checks++;
        if (!got || {r, f, d} !== {e.rise, e.fall, e.dout}) begin
            errors++;
            $display("FAIL reset_mid_setup: got seen=%0d rise %b dout %b, expected rise %b dout %b",
                     got, r, d, e.rise, e.dout);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_tick_wait: got no tick in 8 cycles, expected one");
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        fc = fall_cnt[0] + fall_cnt[1];
        rst_n   = 1'b0;
        bus.din = 2'b00;
        #1;
        checks++;
        if ({bus.dout, bus.rise, bus.fall, bus.tick, bus.long_press} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %b, expected all 0",
                     {bus.dout, bus.rise, bus.fall, bus.tick, bus.long_press});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.tick !== ((n % 4) == 3)) begin
                errors++;
                $display("FAIL reset_mid_tick edge %0d: got %b, expected %b", n, bus.tick, ((n % 4) == 3));
            end
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ((fall_cnt[0] + fall_cnt[1]) != fc || bus.dout !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_no_fall: falls %0d dout %b, expected falls 0 dout 00",
                     fall_cnt[0] + fall_cnt[1] - fc, bus.dout);
        end
    endtask

    task automatic test_final();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL rise_and_fall_together: got %0d cycles, expected 0", both_cnt);
        end
        checks++;
        if (dbl_cnt != 0) begin
            errors++;
            $display("FAIL pulse_wider_than_one: got %0d cycles, expected 0", dbl_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
`ifndef DEBOUNCE_LONGPRESS_EN
        checks++;
        if (lp_cnt != 0) begin
            errors++;
            $display("FAIL long_press_tied_off: got %0d pulses, expected 0", lp_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_step();
        test_chatter();
        test_both_release();
`ifdef DEBOUNCE_LONGPRESS_EN
        test_long_press();
`endif
        test_reset_mid();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
